// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} uart_tx_state_e;
  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter. o_bit_done is high on the last clock of each bit period;
// i_clr holds the count at zero.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_bit_done
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last     = (r_cnt == LAST);
  assign o_bit_done = w_last && !i_clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_cnt <= '0;
    else if (i_clr)  r_cnt <= '0;
    else if (w_last) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with registered tx/busy.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy
);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_tx_state_e       r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [IDX_W-1:0]     r_bit_idx;
  logic                 r_tx;
  logic                 r_busy;
  logic                 w_bit_done;
  logic                 w_cnt_clr;

  // Counter sits at zero while idle so START gets a full bit period.
  assign w_cnt_clr = (r_state == IDLE);

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_cnt_clr),
    .o_bit_done (w_bit_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= IDLE_LEVEL;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx   <= IDLE_LEVEL;
          r_busy <= 1'b0;
          if (start) begin
            r_shift   <= data_in;
            r_bit_idx <= '0;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= START;
          end
        end
        START: if (w_bit_done) begin
          r_tx      <= r_shift[0];
          r_bit_idx <= '0;
          r_state   <= DATA;
        end
        DATA: if (w_bit_done) begin
          if (r_bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            r_tx    <= ^r_shift;
            r_state <= PARITY;
`else
            r_tx    <= IDLE_LEVEL;
            r_state <= STOP;
`endif
          end else begin
            r_tx      <= r_shift[r_bit_idx + 1'b1];
            r_bit_idx <= r_bit_idx + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (w_bit_done) begin
          r_tx    <= IDLE_LEVEL;
          r_state <= STOP;
        end
`endif
        STOP: if (w_bit_done) begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_tx    <= IDLE_LEVEL;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=8 with mid-bit sampling.
module tb_uart_tx;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .data_in (data_in),
    .tx      (tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Sends one frame and checks every bit at its midpoint. If inj >= 0, a
  // start pulse carrying 8'h55 is injected at that bit's sample point.
  task automatic send_frame(input logic [7:0] d, input int inj);
    logic [9:0] exp_bits;
    exp_bits = {1'b1, d, 1'b0};
    start = 1'b1;
    data_in = d;
    tick(1);
    chk("tx_fall_latency", tx, 1'b0);
    chk("busy_rise", busy, 1'b1);
    start = 1'b0;
    data_in = 8'hEE;
    tick(N/2);
    for (int k = 0; k < 10; k++) begin
`ifdef UART_TX_PARITY_EN
      if (k == 9) begin
        chk("parity_bit", tx, ^d);
        tick(N);
      end
`endif
      chk($sformatf("bit%0d_of_%h", k, d), tx, exp_bits[k]);
      chk($sformatf("busy_bit%0d", k), busy, 1'b1);
      if (k == 9) break;
      if (k == inj) begin
        start = 1'b1;
        data_in = 8'h55;
        tick(1);
        start = 1'b0;
        tick(N - 1);
      end else begin
        tick(N);
      end
    end
    // Now N/2 clocks into stop; busy must fall exactly at the frame end.
    tick(N/2 - 1);
    chk("busy_before_end", busy, 1'b1);
    tick(1);
    chk("busy_fall", busy, 1'b0);
    chk("tx_idle_after", tx, 1'b1);
  endtask

  initial begin
    // Reset held for two cycles, then idle without start.
    tick(2);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("idle_tx", tx, 1'b1);
      chk("idle_busy", busy, 1'b0);
    end

    send_frame(8'hB7, -1);

    // Back-to-back: second start in the first idle cycle.
    send_frame(8'h00, -1);
    send_frame(8'hFF, -1);

    // Start pulse mid-frame must be ignored.
    tick(3);
    send_frame(8'hA3, 3);
    for (int i = 0; i < 2*N; i++) begin
      tick(1);
      chk("no_second_frame_tx", tx, 1'b1);
      chk("no_second_frame_busy", busy, 1'b0);
    end

    // Asynchronous reset during data bit 3 of 8'h0F.
    start = 1'b1;
    data_in = 8'h0F;
    tick(1);
    start = 1'b0;
    chk("rst_frame_start", tx, 1'b0);
    tick(N/2 + 4*N - 1);
    chk("rst_frame_busy", busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    tick(2);
    chk("rst_hold_tx", tx, 1'b1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("post_rst_idle_tx", tx, 1'b1);
      chk("post_rst_idle_busy", busy, 1'b0);
    end
    send_frame(8'h3C, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Fixed-format 8N1 UART transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity by default.
- Accepts a byte on a single-cycle start strobe and serializes it onto tx.
- Each bit lasts CLKS_PER_BIT clocks.
- Sits between a byte-producing controller and the serial output pad; busy provides flow control.

Parameters:
- CLKS_PER_BIT, default 16: system clocks per serial bit; legal range 2..65535; the bench uses 8.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  request strobe; sampled on rising clk.
- data_in  input  8  byte to send; captured in the cycle start is accepted.
- tx  output  1  serial line, idle high; registered output.
- busy  output  1  high while a frame is in progress; registered output.

Behaviour:
- Reset (reset=0) forces, asynchronously: tx=1, busy=0, state IDLE, bit counter 0, clock counter 0, shift register 0.
- Reset mid-frame aborts the frame immediately; tx returns high with no glitch low. After release, the block waits in IDLE.
- States: IDLE, START, DATA, STOP (register-encoded, one state register).
- IDLE:
  - tx=1, busy=0.
  - start=1 at a rising edge means acceptance: data_in is latched into the shift register, the clock counter clears, and the state becomes START.
- START:
  - tx=0 and busy=1 from the edge that accepts start.
  - Latency: tx falls exactly 1 clock edge after start is sampled high.
  - Holds for CLKS_PER_BIT clocks, then goes to DATA with bit index 0.
- DATA:
  - tx = latched bit[index], LSB first.
  - Each bit holds for CLKS_PER_BIT clocks.
  - The index increments after each bit; after bit 7 the state goes to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT clocks, then IDLE.
  - busy falls on the same edge that enters IDLE.
- Frame timing:
  - Total frame is exactly 10*CLKS_PER_BIT clocks from the tx falling edge to busy falling.
  - Mid-bit sample points sit CLKS_PER_BIT/2 + k*CLKS_PER_BIT clocks after the tx fall.
- start while busy=1 is ignored; no queuing, no effect on the current frame.
- data_in changes after acceptance have no effect on the current frame.
- start high in the first IDLE cycle after a frame ends is accepted, giving a minimum 1-cycle gap between frames.
- start held high for several cycles sends one frame, then another once IDLE is reached if still high. Level-sensitive in IDLE; callers pulse it for one cycle.
- The clock counter is sized $clog2(CLKS_PER_BIT) bits, wraps at CLKS_PER_BIT-1, and never overflows.
- No X propagation: tx and busy are always driven 0 or 1 after reset.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - tx carries the even parity bit (XOR of the 8 latched data bits) for CLKS_PER_BIT clocks.
  - Frame becomes 11*CLKS_PER_BIT clocks; busy covers the parity bit.
- Undefined: the PARITY state and its logic are absent; the frame is 8N1 as above.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] uart_tx_state_e {IDLE, START, DATA, STOP, PARITY};
  - localparam DATA_BITS = 8;
  - localparam IDLE_LEVEL = 1'b1.
- Sub-module uart_baud_cnt (natural split):
  - CLKS_PER_BIT-parameterized counter with clear input and bit_done pulse.
  - Output is high on the last clock of each bit period.
  - uart_tx instantiates it once.

Test Plan:
- Reset held low 2 cycles, then released -> tx=1, busy=0 throughout; no activity without start.
- CLKS_PER_BIT=8, one-cycle start with data_in=8'hB7 -> tx low 1 edge later. Mid-bit samples give start 0, data bits 1,1,1,0,1,1,0,1, stop 1. busy=1 during the frame; busy=0 exactly 80 clocks after the tx fall.
- Frame 8'h00 followed by 8'hFF, second start in the first idle cycle after busy falls -> both frames correct. Gap between the end of stop and the next start bit is 1 clock.
- start pulsed with 8'h55 mid-frame while sending 8'hA3 -> 8'hA3 frame unaltered; no second frame; busy falls after 80 clocks.
- reset driven low during data bit 3 of 8'h0F -> tx=1 and busy=0 immediately (asynchronously). After release, a new 8'h3C frame is sent correctly.
- With UART_TX_PARITY_EN, send 8'hB7 (six ones) -> parity bit 0 after bit 7, then stop 1. busy=0 after 88 clocks.
